// File: rtl/syscall_ctrl.sv
// Syscall service controller: decodes print/exit codes, stalls the CPU and hands prints to a sink.
// Optional EMIT timeout enabled by defining SYSCALL_TIMEOUT_EN.
module syscall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sys_req,
  input  logic [7:0]       v0,
  input  logic [31:0]      a0,
  output logic             stall,
  output logic             halted,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic [31:0]      out_data,
  output logic [31:0]      hex_out,
  output logic [CNT_W-1:0] sys_count,
  output logic             err
);
  // state | meaning
  // IDLE  | waiting for a syscall in execute
  // EMIT  | print transfer offered to the sink
  // DONE  | one-cycle retire, CPU advances past the syscall
  // HALT  | exit taken, terminal until reset
  typedef enum logic [1:0] {IDLE, EMIT, DONE, HALT} state_t;

  localparam logic [7:0] CODE_INT  = 8'd1;
  localparam logic [7:0] CODE_EXIT = 8'd10;
  localparam logic [7:0] CODE_CHAR = 8'd11;

  state_t           state, state_nx;
  logic [1:0]       kind_q;
  logic [31:0]      data_q;
  logic [31:0]      hex_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_hit;

`ifdef SYSCALL_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TW-1:0] tmr_q;
  logic          err_q;

  assign tmo_hit = (tmr_q == '0);

  // Down-counter loaded on EMIT entry; reaching zero while still unready ends the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && state_nx == EMIT)
        tmr_q <= TW'(TIMEOUT - 1);
      else if (state == EMIT && !out_ready && !tmo_hit)
        tmr_q <= tmr_q - 1'b1;
      if (state == EMIT && !out_ready && tmo_hit)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (sys_req) begin
        case (v0)
          CODE_INT, CODE_CHAR: state_nx = EMIT;
          CODE_EXIT:           state_nx = HALT;
          default:             state_nx = DONE;
        endcase
      end
      EMIT: if (out_ready || tmo_hit) state_nx = DONE;
      DONE: state_nx = IDLE;
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall     = (state == IDLE && sys_req) || state == EMIT || state == HALT;
    halted    = (state == HALT);
    out_valid = (state == EMIT);
    out_kind  = (state == EMIT) ? kind_q : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q <= 2'b00;
      data_q <= '0;
      hex_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (state == IDLE && sys_req) begin
        cnt_q <= cnt_q + 1'b1;
        if (v0 == CODE_INT) begin
          kind_q <= 2'b01;
          data_q <= a0;
        end else if (v0 == CODE_CHAR) begin
          kind_q <= 2'b10;
          data_q <= {24'b0, a0[7:0]};
        end
      end
      if (state == EMIT && out_ready && kind_q == 2'b01)
        hex_q <= data_q;
    end
  end

  assign out_data  = data_q;
  assign hex_out   = hex_q;
  assign sys_count = cnt_q;
endmodule

// File: tb/tb_syscall_ctrl.sv
// Directed bench for syscall_ctrl: transaction-level model checked every cycle plus literal scenario checks.
module tb_syscall_ctrl;
  localparam int CNT_W = 16;
  localparam int TMO   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sys_req = 1'b0;
  logic [7:0]       v0 = '0;
  logic [31:0]      a0 = '0;
  logic             out_ready = 1'b0;
  logic             stall, halted, out_valid, err;
  logic [1:0]       out_kind;
  logic [31:0]      out_data, hex_out;
  logic [CNT_W-1:0] sys_count;

  int vecs = 0;
  int errs = 0;

  syscall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .sys_req(sys_req), .v0(v0), .a0(a0),
    .stall(stall), .halted(halted), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_data(out_data), .hex_out(hex_out),
    .sys_count(sys_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: a syscall is either pending a transfer, retiring, or the machine has exited.
  logic             m_halted, m_xfer, m_retire, m_err;
  logic [1:0]       m_kind;
  logic [31:0]      m_data, m_hex;
  logic [CNT_W-1:0] m_count;
  int               m_wait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halted <= 1'b0; m_xfer <= 1'b0; m_retire <= 1'b0; m_err <= 1'b0;
      m_kind <= 2'b00; m_data <= '0; m_hex <= '0; m_count <= '0; m_wait <= 0;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (m_xfer) begin
      if (out_ready) begin
        if (m_kind == 2'b01) m_hex <= m_data;
        m_xfer <= 1'b0;
        m_retire <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
`ifdef SYSCALL_TIMEOUT_EN
        if (m_wait + 1 == TMO) begin
          m_xfer <= 1'b0;
          m_retire <= 1'b1;
          m_err <= 1'b1;
        end
`endif
      end
    end else if (m_retire) begin
      m_retire <= 1'b0;
    end else if (sys_req) begin
      m_count <= m_count + 1'b1;
      m_wait <= 0;
      if (v0 == 8'd1) begin
        m_xfer <= 1'b1; m_kind <= 2'b01; m_data <= a0;
      end else if (v0 == 8'd11) begin
        m_xfer <= 1'b1; m_kind <= 2'b10; m_data <= {24'b0, a0[7:0]};
      end else if (v0 == 8'd10) begin
        m_halted <= 1'b1;
      end else begin
        m_retire <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_stall", 32'(stall), 32'(m_halted | m_xfer | (sys_req & ~m_retire)));
    chk("m_halted", 32'(halted), 32'(m_halted));
    chk("m_out_valid", 32'(out_valid), 32'(m_xfer));
    chk("m_out_kind", 32'(out_kind), m_xfer ? 32'(m_kind) : 32'd0);
    if (m_xfer) chk("m_out_data", out_data, m_data);
    chk("m_hex_out", hex_out, m_hex);
    chk("m_sys_count", 32'(sys_count), 32'(m_count));
    chk("m_err", 32'(err), 32'(m_err));
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_hex", hex_out, 32'd0);
    chk("rst_count", 32'(sys_count), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // integer print, sink ready immediately
    sys_req = 1'b1; v0 = 8'd1; a0 = 32'h0000_BEEF; out_ready = 1'b1;
    @(negedge clk); chk("int_stall0", 32'(stall), 32'd1);
    tick;
    @(negedge clk);
    chk("int_stall1", 32'(stall), 32'd1);
    chk("int_valid", 32'(out_valid), 32'd1);
    chk("int_kind", 32'(out_kind), 32'd1);
    chk("int_data", out_data, 32'h0000_BEEF);
    tick;
    @(negedge clk);
    chk("int_stall2", 32'(stall), 32'd0);
    chk("int_valid_done", 32'(out_valid), 32'd0);
    chk("int_hex", hex_out, 32'h0000_BEEF);
    chk("int_count", 32'(sys_count), 32'd1);
    tick;
    sys_req = 1'b0; out_ready = 1'b0;
    tick;

    // character print with a slow sink
    sys_req = 1'b1; v0 = 8'd11; a0 = 32'h1234_5641;
    tick;
    for (int i = 0; i < 6; i++) begin
      out_ready = (i == 5);
      @(negedge clk);
      chk("chr_valid", 32'(out_valid), 32'd1);
      chk("chr_kind", 32'(out_kind), 32'd2);
      chk("chr_data", out_data, 32'h0000_0041);
      chk("chr_stall", 32'(stall), 32'd1);
      chk("chr_hex", hex_out, 32'h0000_BEEF);
      tick;
    end
    @(negedge clk);
    chk("chr_done_valid", 32'(out_valid), 32'd0);
    chk("chr_done_kind", 32'(out_kind), 32'd0);
    chk("chr_count", 32'(sys_count), 32'd2);
    tick;
    sys_req = 1'b0; out_ready = 1'b0;
    tick;

    // non-printing code
    sys_req = 1'b1; v0 = 8'd7; a0 = 32'hFFFF_FFFF;
    @(negedge clk); chk("oth_stall0", 32'(stall), 32'd1);
    tick;
    @(negedge clk);
    chk("oth_stall1", 32'(stall), 32'd0);
    chk("oth_valid", 32'(out_valid), 32'd0);
    chk("oth_count", 32'(sys_count), 32'd3);
    tick;
    sys_req = 1'b0;
    tick;

`ifdef SYSCALL_TIMEOUT_EN
    sys_req = 1'b1; v0 = 8'd1; a0 = 32'h0000_0055; out_ready = 1'b0;
    tick;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      chk("tmo_valid", 32'(out_valid), 32'd1);
      chk("tmo_err_pre", 32'(err), 32'd0);
      tick;
    end
    @(negedge clk);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_valid_done", 32'(out_valid), 32'd0);
    chk("tmo_hex", hex_out, 32'h0000_BEEF);
    tick;
    sys_req = 1'b0;
    tick;
`else
    @(negedge clk); chk("err_tied", 32'(err), 32'd0);
`endif

    // reset in the middle of a transfer
    sys_req = 1'b1; v0 = 8'd1; a0 = 32'hCAFE_0001; out_ready = 1'b0;
    tick;
    tick;
    #1;
    rst_n = 1'b0; sys_req = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_hex", hex_out, 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_count", 32'(sys_count), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // exit, then later syscalls are ignored
    sys_req = 1'b1; v0 = 8'd10; a0 = '0;
    tick;
    @(negedge clk);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_stall", 32'(stall), 32'd1);
    v0 = 8'd1; a0 = 32'h0000_1111; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      @(negedge clk);
      chk("halt_valid", 32'(out_valid), 32'd0);
      chk("halt_stall_hold", 32'(stall), 32'd1);
      chk("halt_count", 32'(sys_count), 32'd1);
    end
    tick;
    sys_req = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst", 32'(halted), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/syscall_ctrl.md
SYSCALL_CTRL -- requirements
Module: syscall_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the serviced-syscall counter.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the max EMIT wait in cycles (used only with SYSCALL_TIMEOUT_EN).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on posedge clk.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port sys_req, input, 1 bit: a syscall instruction is in execute.
REQ-006 Port v0, input, 8 bits: syscall code.
REQ-007 Port a0, input, 32 bits: syscall argument.
REQ-008 Port stall, output, 1 bit: hold PC and register writes.
REQ-009 Port halted, output, 1 bit: sticky exit indication.
REQ-010 Port out_valid, output, 1 bit: console or display transfer valid.
REQ-011 Port out_ready, input, 1 bit: the sink accepts the transfer.
REQ-012 Port out_kind, output, 2 bits: 01 = integer/hex, 10 = character, 00 = none.
REQ-013 Port out_data, output, 32 bits: transfer payload.
REQ-014 Port hex_out, output, 32 bits: last integer printed, held for the display.
REQ-015 Port sys_count, output, CNT_W bits: number of syscalls accepted.
REQ-016 Port err, output, 1 bit: sticky timeout flag.

Function
REQ-017 The block SHALL implement FSM states IDLE, EMIT, DONE and HALT.
REQ-018 In IDLE with sys_req=1, decoding SHALL be: v0=1 -> EMIT, out_kind 01, out_data=a0.
REQ-019 Decoding SHALL continue: v0=11 -> EMIT, out_kind 10, out_data={24'b0,a0[7:0]}.
REQ-020 Decoding SHALL continue: v0=10 -> HALT; any other code -> DONE, with no output transfer.
REQ-021 out_data and out_kind SHALL be registered on leaving IDLE and held stable throughout EMIT.
REQ-022 out_valid SHALL equal 1 exactly while in EMIT; out_kind SHALL read 00 outside EMIT.
REQ-023 The EMIT transfer SHALL complete on a posedge with out_ready=1, then go to DONE; out_valid SHALL never drop before completion.
REQ-024 On completion with out_kind 01, hex_out SHALL load out_data on that same edge; hex_out SHALL be otherwise unchanged.
REQ-025 stall SHALL be combinational: 1 when (IDLE and sys_req) or EMIT or HALT; 0 in DONE.
REQ-026 DONE SHALL last exactly one cycle, then go to IDLE; sys_req is ignored in DONE, since the CPU advances past the syscall on that edge.
REQ-027 Latency: print syscall minimum 3 cycles (IDLE, EMIT with ready, DONE); non-printing code 2 cycles.
REQ-028 HALT SHALL be terminal until reset, with halted=1, stall=1 and all inputs ignored.
REQ-029 sys_count SHALL increment by 1, modulo 2^CNT_W, on every exit from IDLE (including to HALT).
REQ-030 If out_ready is already 1 on entry to EMIT, completion SHALL occur on the first EMIT edge.

Reset
REQ-031 While rst_n=0, the outputs SHALL be: state IDLE, stall=0, halted=0, out_valid=0, out_kind=00, out_data=0, hex_out=0, sys_count=0, err=0.
REQ-032 rst_n asserted mid-EMIT SHALL abort the transfer immediately, without completing it or updating hex_out.
REQ-033 rst_n asserted in HALT SHALL clear halted.

Configuration
REQ-034 With SYSCALL_TIMEOUT_EN defined, a cycle counter SHALL run in EMIT, and TIMEOUT EMIT cycles without out_ready SHALL drop the transfer to DONE and set err=1 (sticky), with hex_out unchanged.
REQ-035 Without SYSCALL_TIMEOUT_EN, EMIT SHALL wait indefinitely, and err SHALL be tied to 0.

Verification
REQ-036 Scenario: v0=1, a0=0x0000_BEEF, out_ready=1 -> out_valid for 1 cycle, out_kind=01, hex_out=0x0000BEEF, stall 1,1,0, sys_count=1.
REQ-037 Scenario: v0=11, a0=0x1234_5641, out_ready low for 5 cycles -> out_data=0x41 held 6 cycles, stall held, hex_out unchanged.
REQ-038 Scenario: v0=10 -> halted=1 next cycle; later sys_req with v0=1 -> no out_valid, stall remains 1.
REQ-039 Scenario: v0=7 -> no out_valid, stall for 1 cycle, DONE, then IDLE; sys_count increments.
REQ-040 Scenario: rst_n pulsed low during EMIT -> out_valid=0 immediately, hex_out=0, state IDLE.
REQ-041 Scenario: with SYSCALL_TIMEOUT_EN, TIMEOUT=4 and out_ready=0 -> EMIT for 4 cycles, then err=1, then DONE.
